guvm_inst_feeder: RTL and testbench
===================================

GUVM_INST_FEEDER -- requirements
Module: guvm_inst_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 8: instruction FIFO entries, power of two, 2..64.
REQ-002 SHALL have parameter NOP_WORD, default 32'h01000000: SPARC nop, injected on starvation and flush.
REQ-003 SHALL have parameter STALL_LIMIT, default 16: maximum WAIT cycles before NOP injection, 1..255.
REQ-004 SHALL have port clk, input, 1: sole clock, rising-edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port inst_in, input, 32: instruction word from the bench driver.
REQ-007 SHALL have port inst_valid, input, 1: inst_in valid this cycle.
REQ-008 SHALL have port inst_ready, output, 1: FIFO can accept a word; combinational, equals count < DEPTH.
REQ-009 SHALL have port fetch_req, input, 1: single-cycle core fetch strobe.
REQ-010 SHALL have port flush, input, 1: core pipeline flush.
REQ-011 SHALL have port icache_data, output, 32: instruction to core (icache_output.data).
REQ-012 SHALL have port icache_hold, output, 1: 1 = not held; 0 = stall core.
REQ-013 SHALL have port icache_mds, output, 1: one-cycle strobe marking a delivered word.
REQ-014 SHALL have port starve, output, 1: one-cycle pulse on NOP injection.
REQ-015 SHALL have port count, output, clog2(DEPTH+1): current FIFO occupancy.

Function
REQ-016 SHALL accept a push when inst_valid && inst_ready; the word becomes poppable the next cycle (no bypass).
REQ-017 SHALL register icache_data, icache_hold, icache_mds and starve; all SHALL change only on the clk rising edge.
REQ-018 SHALL implement states IDLE and WAIT.
REQ-019 In IDLE with fetch_req && count>0: pop head to icache_data, icache_mds=1 next cycle, stay IDLE (1-cycle latency; back-to-back fetches deliver one word per cycle).
REQ-020 In IDLE with fetch_req && count==0: go to WAIT, icache_hold=0 next cycle, clear stall counter.
REQ-021 In WAIT with count>0: pop head, icache_hold=1, icache_mds=1 next cycle, go to IDLE.
REQ-022 In WAIT, fetch_req SHALL be ignored (a request is already outstanding).
REQ-023 In WAIT with count==0: increment stall counter.
REQ-024 In WAIT, when the stall counter reaches STALL_LIMIT-1 with count still 0: output icache_data=NOP_WORD, icache_hold=1, icache_mds=1, starve=1 for one cycle, go to IDLE.
REQ-025 icache_mds and starve SHALL be 0 in every cycle not named above; icache_data SHALL hold its last value between deliveries.
REQ-026 flush SHALL take priority over push, pop and fetch_req in the same cycle: next cycle count=0, state=IDLE, icache_hold=1, icache_data=NOP_WORD, icache_mds=0; a push in the flush cycle is dropped.
REQ-027 Push and pop in the same cycle SHALL leave count unchanged; read/write pointers wrap modulo DEPTH.
REQ-028 When full, inst_ready=0 and inst_valid SHALL be ignored; a same-cycle pop does not make room until the following cycle.

Reset
REQ-029 With rst high at a clk edge: state=IDLE, count=0, pointers=0, stall counter=0, icache_data=NOP_WORD, icache_hold=1, icache_mds=0, starve=0; inst_ready=1 after reset.
REQ-030 rst asserted mid-operation (including in WAIT) SHALL discard FIFO contents and any outstanding request, with no mds or starve pulse.
REQ-031 rst SHALL take priority over flush, push and fetch_req.

Verification
REQ-032 Push 32'h8E00C002 and 32'h82102005, then fetch_req on 2 consecutive cycles -> icache_data equals each word in order, mds=1 both cycles, hold=1 throughout, count 2->1->0.
REQ-033 fetch_req with FIFO empty, push 32'h86004002 three cycles later -> hold=0 from the next cycle until that word is delivered, then hold=1 and mds=1; starve stays 0.
REQ-034 fetch_req with FIFO empty and no push for STALL_LIMIT=16 cycles -> icache_data=32'h01000000, starve=1 and mds=1 for exactly one cycle, hold returns to 1.
REQ-035 Fill 8 words, then keep inst_valid high -> inst_ready=0 and count=8; pop one -> next cycle inst_ready=1; 16 push/pop cycles verify pointer wrap with order preserved.
REQ-036 5 words queued, flush asserted with simultaneous push and fetch_req -> next cycle count=0, icache_data=32'h01000000, mds=0, state=IDLE; assert rst during WAIT -> all REQ-029 values next cycle.

Source files
------------

// File: rtl/guvm_inst_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module   : guvm_inst_feeder_if
//  Purpose  : Bundles the instruction-push and core-fetch signals of
//             guvm_inst_feeder into one interface.
//  Signals  : inst_in/inst_valid/inst_ready - instruction push handshake
//             fetch_req/flush               - core fetch strobe and flush
//             icache_data/hold/mds          - instruction delivery to core
//             starve                        - NOP-injection pulse
//             count                         - FIFO occupancy
//  Modports : master - bench driver / core side
//             slave  - the feeder itself
//  Revision : 1.0 - initial release
// ============================================================================
interface guvm_inst_feeder_if #(
   parameter int DEPTH = 8
);
   logic [31:0]                  inst_in;
   logic                         inst_valid;
   logic                         inst_ready;
   logic                         fetch_req;
   logic                         flush;
   logic [31:0]                  icache_data;
   logic                         icache_hold;
   logic                         icache_mds;
   logic                         starve;
   logic [$clog2(DEPTH+1)-1:0]   count;

   modport master (
      output inst_in, inst_valid, fetch_req, flush,
      input  inst_ready, icache_data, icache_hold, icache_mds, starve, count
   );

   modport slave (
      input  inst_in, inst_valid, fetch_req, flush,
      output inst_ready, icache_data, icache_hold, icache_mds, starve, count
   );
endinterface
`default_nettype wire

// File: rtl/guvm_inst_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : guvm_inst_feeder
//  Purpose  : Instruction FIFO that feeds a core's icache port. Fetches are
//             served from the FIFO head with one cycle of latency; an empty
//             FIFO stalls the core (icache_hold=0) and, if starvation lasts
//             STALL_LIMIT cycles, a NOP word is injected instead.
//  Ports    : clk  - rising-edge clock
//             rst  - synchronous active-high reset
//             bus  - guvm_inst_feeder_if.slave (push, fetch, flush, delivery)
//  Revision : 1.0 - initial release
// ============================================================================
module guvm_inst_feeder #(
   parameter int          DEPTH       = 8,
   parameter logic [31:0] NOP_WORD    = 32'h01000000,
   parameter int          STALL_LIMIT = 16
) (
   input  wire logic           clk,
   input  wire logic           rst,
   guvm_inst_feeder_if.slave   bus
);
   localparam int c_AW = $clog2(DEPTH);
   localparam int c_CW = $clog2(DEPTH + 1);
   localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(DEPTH);
   localparam logic [7:0]      c_STALL_MAX = 8'(STALL_LIMIT - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [31:0]       r_mem [DEPTH];
   logic [c_AW-1:0]   r_wr_ptr, r_rd_ptr;
   logic [c_CW-1:0]   r_count;
   logic [7:0]        r_stall, w_stall_nxt;
   logic [31:0]       r_data, w_data_nxt;
   logic              r_hold, w_hold_nxt;
   logic              r_mds, w_mds_nxt;
   logic              r_starve, w_starve_nxt;
   logic              w_ready, w_empty, w_push, w_pop;

   assign w_ready = (r_count < c_DEPTH_CNT);
   assign w_empty = (r_count == '0);
   // Readiness comes from the registered count, so a pop in a full cycle
   // frees a slot only from the next cycle on. Flush drops any push.
   assign w_push  = bus.inst_valid && w_ready && !bus.flush;

   assign bus.inst_ready  = w_ready;
   assign bus.count       = r_count;
   assign bus.icache_data = r_data;
   assign bus.icache_hold = r_hold;
   assign bus.icache_mds  = r_mds;
   assign bus.starve      = r_starve;

   always_comb begin
      w_state_nxt  = r_state;
      w_stall_nxt  = r_stall;
      w_pop        = 1'b0;
      w_data_nxt   = r_data;
      w_hold_nxt   = r_hold;
      w_mds_nxt    = 1'b0;
      w_starve_nxt = 1'b0;
      if (bus.flush) begin
         w_state_nxt = ST_IDLE;
         w_stall_nxt = '0;
         w_data_nxt  = NOP_WORD;
         w_hold_nxt  = 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.fetch_req) begin
                  if (!w_empty) begin
                     w_pop      = 1'b1;
                     w_data_nxt = r_mem[r_rd_ptr];
                     w_hold_nxt = 1'b1;
                     w_mds_nxt  = 1'b1;
                  end else begin
                     w_state_nxt = ST_WAIT;
                     w_stall_nxt = '0;
                     w_hold_nxt  = 1'b0;
                  end
               end
            end
            ST_WAIT: begin
               // fetch_req is ignored here: one request is already pending.
               if (!w_empty) begin
                  w_pop       = 1'b1;
                  w_data_nxt  = r_mem[r_rd_ptr];
                  w_hold_nxt  = 1'b1;
                  w_mds_nxt   = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else if (r_stall == c_STALL_MAX) begin
                  w_data_nxt   = NOP_WORD;
                  w_hold_nxt   = 1'b1;
                  w_mds_nxt    = 1'b1;
                  w_starve_nxt = 1'b1;
                  w_state_nxt  = ST_IDLE;
                  w_stall_nxt  = '0;
               end else begin
                  w_stall_nxt = r_stall + 8'd1;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_stall  <= '0;
         r_count  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_data   <= NOP_WORD;
         r_hold   <= 1'b1;
         r_mds    <= 1'b0;
         r_starve <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_stall  <= w_stall_nxt;
         r_data   <= w_data_nxt;
         r_hold   <= w_hold_nxt;
         r_mds    <= w_mds_nxt;
         r_starve <= w_starve_nxt;
         if (bus.flush) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap.
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
         end
      end
   end

   // Storage needs no reset: occupancy alone decides what is readable.
   always_ff @(posedge clk) begin
      if (!rst && w_push) r_mem[r_wr_ptr] <= bus.inst_in;
   end
endmodule
`default_nettype wire

// File: tb/tb_guvm_inst_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_guvm_inst_feeder
//  Purpose  : Self-checking bench for guvm_inst_feeder: directed scenarios
//             followed by randomized traffic, all compared each cycle
//             against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_guvm_inst_feeder;
   localparam int          DEPTH       = 8;
   localparam logic [31:0] NOP         = 32'h01000000;
   localparam int          STALL_LIMIT = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   guvm_inst_feeder_if #(.DEPTH(DEPTH)) bus ();

   guvm_inst_feeder #(
      .DEPTH(DEPTH),
      .NOP_WORD(NOP),
      .STALL_LIMIT(STALL_LIMIT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: queued words, whether a fetch is outstanding, and
   // how many empty cycles it has waited so far.
   logic [31:0] m_q[$];
   bit          m_pending;
   int          m_waited;
   logic [31:0] m_data;
   bit          m_hold, m_mds, m_starve;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_step(input bit r, input bit f, input bit v, input logic [31:0] d, input bit fr);
      bit room;
      bit deliver;
      if (r) begin
         m_q.delete();
         m_pending = 0; m_waited = 0;
         m_data = NOP; m_hold = 1; m_mds = 0; m_starve = 0;
      end else if (f) begin
         m_q.delete();
         m_pending = 0; m_waited = 0;
         m_data = NOP; m_hold = 1; m_mds = 0; m_starve = 0;
      end else begin
         room    = (m_q.size() < DEPTH);
         deliver = 0;
         m_mds = 0; m_starve = 0;
         if (!m_pending) begin
            if (fr) begin
               if (m_q.size() > 0) deliver = 1;
               else begin
                  m_pending = 1; m_waited = 0; m_hold = 0;
               end
            end
         end else if (m_q.size() > 0) begin
            deliver = 1;
         end else begin
            m_waited++;
            if (m_waited == STALL_LIMIT) begin
               m_data = NOP; m_hold = 1; m_mds = 1; m_starve = 1;
               m_pending = 0;
            end
         end
         if (deliver) begin
            m_data = m_q.pop_front();
            m_hold = 1; m_mds = 1; m_pending = 0;
         end
         if (v && room) m_q.push_back(d);
      end
   endtask

   // One clock cycle: drive inputs, advance the model, check after the edge.
   task automatic cyc(input bit r, input bit f, input bit v, input logic [31:0] d, input bit fr);
      rst            = r;
      bus.flush      = f;
      bus.inst_valid = v;
      bus.inst_in    = d;
      bus.fetch_req  = fr;
      model_step(r, f, v, d, fr);
      @(posedge clk);
      #1;
      chk_eq("data",   bus.icache_data,      m_data);
      chk_eq("hold",   32'(bus.icache_hold), 32'(m_hold));
      chk_eq("mds",    32'(bus.icache_mds),  32'(m_mds));
      chk_eq("starve", 32'(bus.starve),      32'(m_starve));
      chk_eq("count",  32'(bus.count),       32'(m_q.size()));
      chk_eq("ready",  32'(bus.inst_ready),  32'(m_q.size() < DEPTH));
   endtask

   initial begin
      int pct;
      m_q.delete();
      m_pending = 0; m_waited = 0;
      m_data = 32'hX; m_hold = 0; m_mds = 0; m_starve = 0;
      rst = 1'b1; bus.flush = 1'b0; bus.inst_valid = 1'b0;
      bus.inst_in = '0; bus.fetch_req = 1'b0;
      @(negedge clk);

      // Reset values
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 1, 32'hDEADBEEF, 1);
      chk_eq("rst_data",  bus.icache_data, NOP);
      chk_eq("rst_count", 32'(bus.count), 0);
      chk_eq("rst_ready", 32'(bus.inst_ready), 1);
      chk_eq("rst_hold",  32'(bus.icache_hold), 1);

      // Two words, back-to-back fetches
      cyc(0, 0, 1, 32'h8E00C002, 0);
      cyc(0, 0, 1, 32'h82102005, 0);
      chk_eq("b2b_cnt2", 32'(bus.count), 2);
      cyc(0, 0, 0, 0, 1);
      chk_eq("b2b_w0", bus.icache_data, 32'h8E00C002);
      chk_eq("b2b_cnt1", 32'(bus.count), 1);
      cyc(0, 0, 0, 0, 1);
      chk_eq("b2b_w1", bus.icache_data, 32'h82102005);
      chk_eq("b2b_mds", 32'(bus.icache_mds), 1);
      chk_eq("b2b_cnt0", 32'(bus.count), 0);

      // Fetch on empty, word arrives three cycles later
      cyc(0, 0, 0, 0, 1);
      chk_eq("wait_hold", 32'(bus.icache_hold), 0);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 1, 32'h86004002, 0);
      chk_eq("wait_hold2", 32'(bus.icache_hold), 0);
      cyc(0, 0, 0, 0, 0);
      chk_eq("wait_word", bus.icache_data, 32'h86004002);
      chk_eq("wait_rel", 32'(bus.icache_hold), 1);
      chk_eq("wait_nostarve", 32'(bus.starve), 0);

      // Starvation: NOP injected after STALL_LIMIT empty cycles
      cyc(0, 0, 0, 0, 1);
      for (int i = 1; i < STALL_LIMIT; i++) cyc(0, 0, 0, 0, 0);
      chk_eq("starve_early", 32'(bus.starve), 0);
      cyc(0, 0, 0, 0, 0);
      chk_eq("starve_pulse", 32'(bus.starve), 1);
      chk_eq("starve_nop", bus.icache_data, NOP);
      cyc(0, 0, 0, 0, 0);
      chk_eq("starve_once", 32'(bus.starve), 0);

      // Fill, overflow attempt, pop, then wrap with simultaneous push/pop
      for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1, 32'hA000_0000 + 32'(i), 0);
      cyc(0, 0, 1, 32'hBAD0BAD0, 0);
      chk_eq("full_ready", 32'(bus.inst_ready), 0);
      chk_eq("full_count", 32'(bus.count), DEPTH);
      cyc(0, 0, 1, 32'hBAD1BAD1, 1);
      chk_eq("full_pop", bus.icache_data, 32'hA0000000);
      chk_eq("full_room", 32'(bus.inst_ready), 1);
      for (int i = 0; i < 16; i++) cyc(0, 0, 1, 32'hC000_0000 + 32'(i), 1);

      // Flush with simultaneous push and fetch
      cyc(0, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 1, 32'hD000_0000 + 32'(i), 0);
      cyc(0, 0, 1, 32'hD0000005, 1);
      cyc(0, 1, 1, 32'hEEEEEEEE, 1);
      chk_eq("flush_cnt", 32'(bus.count), 0);
      chk_eq("flush_nop", bus.icache_data, NOP);
      chk_eq("flush_mds", 32'(bus.icache_mds), 0);
      cyc(0, 0, 0, 0, 1);
      chk_eq("flush_idle", 32'(bus.icache_hold), 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(1, 1, 1, 32'h12345678, 1);
      chk_eq("wrst_hold", 32'(bus.icache_hold), 1);
      chk_eq("wrst_count", 32'(bus.count), 0);
      for (int i = 0; i < STALL_LIMIT + 2; i++) cyc(0, 0, 0, 0, 0);

      // Randomized traffic in segments of varying push density
      for (int i = 0; i < 3000; i++) begin
         case ((i / 250) % 4)
            0:       pct = 5;
            1:       pct = 35;
            2:       pct = 70;
            default: pct = 95;
         endcase
         cyc($urandom_range(299) == 0,
             $urandom_range(59) == 0,
             $urandom_range(99) < pct,
             $urandom,
             $urandom_range(2) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
